freq_synth_nco: RTL
===================

# freq_synth_nco

Programmable frequency generator that synthesises a square wave and a per-period tick on the `ref_clk` domain from a requested frequency in Hz. It is the transmit-side counterpart of the frequency counter: the counter measures a target clock against `ref_clk`, and this block produces one. Frequency-to-tuning-word conversion runs on an iterative divider. Output comes from a phase accumulator (NCO).

## Interface
- `REF_HZ`, 10_000_000, `ref_clk` frequency in Hz; constant, nonzero, < 2^32
- `ACC_W`, 32, phase accumulator and tuning word width
- `ref_clk`  in  1  sole clock
- `rst_`  in  1  asynchronous, active-low reset
- `en`  in  1  accumulator advance enable; low freezes phase and outputs
- `load`  in  1  request to program `freq_hz`; accepted only when `ready`=1
- `freq_hz`  in  32  requested frequency in Hz; sampled on accepted `load`
- `stop`  in  1  synchronous stop back to IDLE
- `ready`  out  1  high in IDLE and RUN; low in CALC
- `err`  out  1  sticky; set on rejected request, cleared on next accepted valid `load`
- `tuning_word`  out  ACC_W  word currently applied
- `out_clk`  out  1  synthesised square wave (accumulator MSB)
- `tick`  out  1  one-cycle pulse on every accumulator overflow, i.e. once per output period

## Operation
- States:
  - IDLE: accumulator 0, `out_clk`=0, no ticks.
  - CALC: divider running.
  - RUN: accumulator adds `tuning_word` each `en` cycle.
- Accepted `load`:
  - `freq_hz`=0: go to IDLE, `tuning_word`=0, `err` cleared.
  - `freq_hz` >= REF_HZ/2 (integer compare `2*freq_hz >= REF_HZ`, 33-bit): reject. Set `err`. State and `tuning_word` unchanged.
  - Otherwise: clear `err`, capture `freq_hz`, enter CALC.
- CALC, restoring division:
  - Remainder is 33 bits, initialised to `freq_hz`.
  - Each of ACC_W cycles: remainder <<= 1. If remainder >= REF_HZ, subtract REF_HZ and shift in quotient bit 1, else 0.
  - Result = floor(freq_hz·2^ACC_W / REF_HZ), exact with no rounding.
- CALC exit: load the quotient into `tuning_word`, clear the accumulator to 0 (phase reset), enter RUN.
- RUN:
  - Update: acc <= acc + tuning_word, modulo 2^ACC_W.
  - `tick` = registered carry-out of that add.
  - `out_clk` = registered acc[ACC_W-1].
- `en`=0: accumulator, `out_clk` and divider hold; `tick`=0. CALC also pauses.
- `stop`=1: go to IDLE from any state. Clears accumulator, `out_clk`, `tick`. Keeps `tuning_word` and `err`.
- Priority: `stop` > `load`. `load` is ignored during CALC.

## Timing
- Reset values: IDLE, `ready`=1, `err`=0, `tuning_word`=0, `out_clk`=0, `tick`=0, accumulator 0, divider 0.
- Accepted `load` at edge N:
  - `ready` low from N+1.
  - `tuning_word` valid and RUN from N+ACC_W+1 (with `en` held high).
  - First accumulator add at N+ACC_W+2.
- `tick` and `out_clk` lag the accumulator by one register stage.
- Reload in RUN: the old word keeps running during CALC. It is replaced with a phase reset at CALC exit. No glitch shorter than one `ref_clk` period on `out_clk`.
- Rejected `load`: `err` high at N+1, `ready` stays high.
- `stop` and reset mid-CALC: divider abandoned, no partial word applied.

## Configuration
- `FREQ_SYNTH_BURST_EN` defined:
  - Adds input `burst_len` [15:0], sampled on accepted `load`, and output `done`.
  - Nonzero `burst_len`: RUN counts ticks. After the `burst_len`-th tick, the block returns to IDLE on the next cycle and pulses `done` for one cycle.
  - `burst_len`=0: continuous operation.
- Undefined: no such ports; RUN is continuous until `stop` or reload.

## Test plan
- Reset, then REF_HZ=10_000_000, `load` with `freq_hz`=2_500_000:
  - `tuning_word`=1_073_741_824 exactly ACC_W+1 cycles after accept.
  - `tick` every 4 cycles.
  - `out_clk` pattern 0,0,1,1.
- `freq_hz`=1_000_000 → `tuning_word`=429_496_729; exactly 99 or 100 ticks in 1000 RUN cycles; no `tick` in IDLE.
- `freq_hz`=5_000_000 → `err`=1, `ready`=1, state and word unchanged. Then `freq_hz`=4_999_999 → accepted, `err` cleared, word=2_147_483_218.
- `load` pulsed mid-CALC → ignored. `stop` mid-CALC → IDLE, old `tuning_word` retained. `rst_` low asynchronously mid-RUN → all outputs zero without a clock edge.
- `en` low 10 cycles during RUN → `out_clk` frozen, no `tick`, phase resumes exactly.
- With `FREQ_SYNTH_BURST_EN`: `freq_hz`=2_500_000, `burst_len`=3 → exactly 3 ticks, `done` one cycle after the third, then IDLE with `out_clk`=0.

Source files
------------

// File: rtl/freq_synth_nco.sv
// freq_synth_nco: converts a requested frequency in Hz into an NCO tuning word and
// synthesises out_clk/tick on ref_clk. Define FREQ_SYNTH_BURST_EN for burst mode.
module freq_synth_nco #(
  parameter int unsigned REF_HZ = 32'd10_000_000,
  parameter int unsigned ACC_W  = 32
) (
  input  logic             ref_clk,
  input  logic             rst_,
  input  logic             en,
  input  logic             load,
  input  logic [31:0]      freq_hz,
  input  logic             stop,
  output logic             ready,
  output logic             err,
  output logic [ACC_W-1:0] tuning_word,
  output logic             out_clk,
  output logic             tick
`ifdef FREQ_SYNTH_BURST_EN
  ,
  input  logic [15:0]      burst_len,
  output logic             done
`endif
);

  // state | meaning
  // IDLE  | accumulator cleared, outputs quiet, waiting for load
  // CALC  | restoring divider computing the tuning word; a previous word may keep running
  // RUN   | accumulator advances by tuning_word on every en cycle
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam int unsigned      CNT_W    = $clog2(ACC_W + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ACC_W);
  localparam logic [32:0]      REF33    = 33'(REF_HZ);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             out_clk_q, out_clk_d;
  logic             tick_q, tick_d;
  logic [ACC_W-1:0] tw_q, tw_d;
  logic             err_q, err_d;
  logic [32:0]      rem_q, rem_d;
  logic [ACC_W-1:0] quo_q, quo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bg_q, bg_d;

  logic [ACC_W:0]   sum;
  logic [32:0]      rem_sh;
  logic             rem_ge;
  logic [32:0]      freq_dbl;
  logic             too_fast;
  logic             advance;
  logic             go_idle;

`ifdef FREQ_SYNTH_BURST_EN
  logic [15:0]      blen_pend_q, blen_pend_d;
  logic [15:0]      bleft_q, bleft_d;
  logic             burst_on_q, burst_on_d;
  logic             done_q, done_d;
`endif

  assign sum      = {1'b0, acc_q} + {1'b0, tw_q};
  assign rem_sh   = rem_q << 1;
  assign rem_ge   = (rem_sh >= REF33);
  assign freq_dbl = {freq_hz, 1'b0};
  assign too_fast = (freq_dbl >= REF33);
  // bg_q keeps the previous word running while a reload is being divided
  assign advance  = en && ((state_q == S_RUN) || ((state_q == S_CALC) && bg_q));

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    out_clk_d = out_clk_q;
    tick_d    = 1'b0;
    tw_d      = tw_q;
    err_d     = err_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    bg_d      = bg_q;
    go_idle   = 1'b0;
`ifdef FREQ_SYNTH_BURST_EN
    blen_pend_d = blen_pend_q;
    bleft_d     = bleft_q;
    burst_on_d  = burst_on_q;
    done_d      = 1'b0;
`endif

    if (advance) begin
      acc_d     = sum[ACC_W-1:0];
      tick_d    = sum[ACC_W];
      out_clk_d = acc_q[ACC_W-1];
`ifdef FREQ_SYNTH_BURST_EN
      if ((state_q == S_RUN) && sum[ACC_W] && burst_on_q && (bleft_q != 16'd0))
        bleft_d = bleft_q - 16'd1;
`endif
    end

    if (stop) begin
      go_idle = 1'b1;
    end
`ifdef FREQ_SYNTH_BURST_EN
    else if ((state_q == S_RUN) && burst_on_q && tick_q && (bleft_q == 16'd0)) begin
      go_idle = 1'b1;
      done_d  = 1'b1;
    end
`endif
    else if (load && (state_q != S_CALC)) begin
      if (freq_hz == 32'd0) begin
        go_idle = 1'b1;
        tw_d    = '0;
        err_d   = 1'b0;
      end else if (too_fast) begin
        err_d = 1'b1;
      end else begin
        err_d   = 1'b0;
        rem_d   = {1'b0, freq_hz};
        quo_d   = '0;
        cnt_d   = CNT_INIT;
        bg_d    = (state_q == S_RUN);
        state_d = S_CALC;
`ifdef FREQ_SYNTH_BURST_EN
        blen_pend_d = burst_len;
`endif
      end
    end else if ((state_q == S_CALC) && en) begin
      if (cnt_q != '0) begin
        rem_d = rem_ge ? (rem_sh - REF33) : rem_sh;
        quo_d = {quo_q[ACC_W-2:0], rem_ge};
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        // phase reset: the new word starts from a cleared accumulator
        tw_d      = quo_q;
        acc_d     = '0;
        out_clk_d = 1'b0;
        tick_d    = 1'b0;
        bg_d      = 1'b0;
        state_d   = S_RUN;
`ifdef FREQ_SYNTH_BURST_EN
        bleft_d    = blen_pend_q;
        burst_on_d = (blen_pend_q != 16'd0);
`endif
      end
    end

    if (go_idle) begin
      state_d   = S_IDLE;
      acc_d     = '0;
      out_clk_d = 1'b0;
      tick_d    = 1'b0;
      rem_d     = '0;
      quo_d     = '0;
      cnt_d     = '0;
      bg_d      = 1'b0;
    end
  end

  always_ff @(posedge ref_clk or negedge rst_) begin
    if (!rst_) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      out_clk_q <= 1'b0;
      tick_q    <= 1'b0;
      tw_q      <= '0;
      err_q     <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      bg_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      out_clk_q <= out_clk_d;
      tick_q    <= tick_d;
      tw_q      <= tw_d;
      err_q     <= err_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      bg_q      <= bg_d;
    end
  end

`ifdef FREQ_SYNTH_BURST_EN
  always_ff @(posedge ref_clk or negedge rst_) begin
    if (!rst_) begin
      blen_pend_q <= '0;
      bleft_q     <= '0;
      burst_on_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      blen_pend_q <= blen_pend_d;
      bleft_q     <= bleft_d;
      burst_on_q  <= burst_on_d;
      done_q      <= done_d;
    end
  end

  assign done = done_q;
`endif

  assign ready       = (state_q != S_CALC);
  assign err         = err_q;
  assign tuning_word = tw_q;
  assign out_clk     = out_clk_q;
  assign tick        = tick_q;

endmodule
